pc_gen_btb: RTL and testbench

Parametrised fetch-stage PC generator: the successor to the current always-not-taken PC register. It adds a direct-mapped branch target buffer (BTB) for next-PC prediction, a trap redirect with priority over branch redirects, and configurable PC width, step and reset vector. It sits at the front of the fetch stage, drives the instruction-memory address, and receives redirects and BTB training from the decode/execute stages.

---
 rtl/pc_gen_btb_if.sv | 31 +++
 rtl/pc_gen_btb.sv | 105 ++++++++++
 tb/tb_pc_gen_btb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/pc_gen_btb_if.sv
// Fetch-side bundle between the PC generator and the decode/execute stages:
// flush requests and BTB training come in, the fetch address and prediction go out.
interface pc_gen_btb_if #(
    parameter int unsigned PC_W = 32
);
    logic            stall_F;
    logic            trap_valid;
    logic [PC_W-1:0] trap_pc;
    logic            redirect_valid;
    logic [PC_W-1:0] redirect_pc;
    logic            btb_upd_valid;
    logic [PC_W-1:0] btb_upd_pc;
    logic [PC_W-1:0] btb_upd_target;
    logic            btb_upd_taken;
    logic [PC_W-1:0] PC_F;
    logic [PC_W-1:0] PC_next;
    logic            pred_taken_F;
    logic [PC_W-1:0] pred_target_F;

    modport master (
        output stall_F, trap_valid, trap_pc, redirect_valid, redirect_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        input  PC_F, PC_next, pred_taken_F, pred_target_F
    );

    modport slave (
        input  stall_F, trap_valid, trap_pc, redirect_valid, redirect_pc,
               btb_upd_valid, btb_upd_pc, btb_upd_target, btb_upd_taken,
        output PC_F, PC_next, pred_taken_F, pred_target_F
    );
endinterface

// File: rtl/pc_gen_btb.sv
// Fetch PC generator with a direct-mapped BTB; trap beats redirect beats stall
// beats prediction. Lookup sees only pre-update BTB contents (no bypass).
module pc_gen_btb #(
    parameter int unsigned     PC_W      = 32,
    parameter int unsigned     PC_STEP   = 1,
    parameter logic [PC_W-1:0] RESET_PC  = {PC_W{1'b0}},
    parameter int unsigned     BTB_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    pc_gen_btb_if.slave bus
);
    localparam int unsigned IDX_LSB = $clog2(PC_STEP);
    localparam int unsigned IDX_W   = $clog2(BTB_DEPTH);
    localparam int unsigned TAG_W   = PC_W - IDX_LSB - IDX_W;

    logic [PC_W-1:0]      pc_f_r;
    logic [PC_W-1:0]      pc_next_s;
    logic [PC_W-1:0]      pc_sel_s;
    logic [PC_W-1:0]      pred_target_s;
    logic                 hit_s;
    logic [BTB_DEPTH-1:0] btb_valid_r;
    logic [TAG_W-1:0]     btb_tag_r    [BTB_DEPTH];
    logic [PC_W-1:0]      btb_target_r [BTB_DEPTH];
    logic [IDX_W-1:0]     lkp_idx_s;
    logic [TAG_W-1:0]     lkp_tag_s;
    logic [IDX_W-1:0]     upd_idx_s;
    logic [TAG_W-1:0]     upd_tag_s;

    assign pc_next_s = pc_f_r + PC_W'(PC_STEP);
    assign lkp_idx_s = pc_f_r[IDX_LSB +: IDX_W];
    assign lkp_tag_s = pc_f_r[PC_W-1 -: TAG_W];
    assign upd_idx_s = bus.btb_upd_pc[IDX_LSB +: IDX_W];
    assign upd_tag_s = bus.btb_upd_pc[PC_W-1 -: TAG_W];

    // Sub-step address bits of a trained PC never select an entry.
    if (IDX_LSB > 0) begin : g_lsb
        logic unused_lsb_s;
        assign unused_lsb_s = ^bus.btb_upd_pc[IDX_LSB-1:0];
    end

    // BTB lookup on the current fetch address
    always_comb begin
        hit_s         = 1'b0;
        pred_target_s = pc_next_s;
        if (btb_valid_r[lkp_idx_s] && (btb_tag_r[lkp_idx_s] == lkp_tag_s)) begin
            hit_s         = 1'b1;
            pred_target_s = btb_target_r[lkp_idx_s];
        end else begin
            hit_s         = 1'b0;
            pred_target_s = pc_next_s;
        end
    end

    // Next fetch address selection (reset handled in the register)
    always_comb begin
        pc_sel_s = pc_next_s;
        if (bus.trap_valid) begin
            pc_sel_s = bus.trap_pc;
        end else if (bus.redirect_valid) begin
            pc_sel_s = bus.redirect_pc;
        end else if (bus.stall_F) begin
            pc_sel_s = pc_f_r;
        end else if (hit_s) begin
            pc_sel_s = pred_target_s;
        end else begin
            pc_sel_s = pc_next_s;
        end
    end

    // Fetch PC register
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_f_r <= RESET_PC;
        end else begin
            pc_f_r <= pc_sel_s;
        end
    end

    // Valid bits: set on taken, cleared on not-taken only when the owner matches
    always_ff @(posedge clk) begin
        if (rst) begin
            btb_valid_r <= {BTB_DEPTH{1'b0}};
        end else if (bus.btb_upd_valid) begin
            if (bus.btb_upd_taken) begin
                btb_valid_r[upd_idx_s] <= 1'b1;
            end else if (btb_valid_r[upd_idx_s] && (btb_tag_r[upd_idx_s] == upd_tag_s)) begin
                btb_valid_r[upd_idx_s] <= 1'b0;
            end
        end
    end

    // Tag/target payload; meaningless while the valid bit is clear
    always_ff @(posedge clk) begin
        if (!rst && bus.btb_upd_valid && bus.btb_upd_taken) begin
            btb_tag_r[upd_idx_s]    <= upd_tag_s;
            btb_target_r[upd_idx_s] <= bus.btb_upd_target;
        end
    end

    assign bus.PC_F          = pc_f_r;
    assign bus.PC_next       = pc_next_s;
    assign bus.pred_taken_F  = hit_s;
    assign bus.pred_target_F = pred_target_s;
endmodule

// File: tb/tb_pc_gen_btb.sv
// Bench for pc_gen_btb: directed scenarios plus randomized traffic, all checked
// against an arithmetic model of the fetch PC and BTB.
module tb_pc_gen_btb;
    localparam int STEP_A  = 1;
    localparam int DEPTH_A = 16;
    localparam int MOD_A   = 65536;

    logic clk = 1'b0;
    logic rst_a;
    logic rst_b;
    int   checks   = 0;
    int   failures = 0;

    int m_pc;
    bit m_v [DEPTH_A];
    int m_t [DEPTH_A];
    int m_g [DEPTH_A];

    pc_gen_btb_if #(.PC_W(16)) bus_a ();
    pc_gen_btb_if #(.PC_W(12)) bus_b ();

    pc_gen_btb #(.PC_W(16), .PC_STEP(1), .RESET_PC(16'h0000), .BTB_DEPTH(16))
        dut_a (.clk(clk), .rst(rst_a), .bus(bus_a));
    pc_gen_btb #(.PC_W(12), .PC_STEP(4), .RESET_PC(12'h100), .BTB_DEPTH(4))
        dut_b (.clk(clk), .rst(rst_b), .bus(bus_b));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int m_idx(input int pc);
        return (pc / STEP_A) % DEPTH_A;
    endfunction

    function automatic int m_tag(input int pc);
        return pc / (STEP_A * DEPTH_A);
    endfunction

    function automatic bit m_hit(input int pc);
        return m_v[m_idx(pc)] && (m_t[m_idx(pc)] == m_tag(pc));
    endfunction

    task automatic idle_a();
        bus_a.stall_F = 1'b0;        bus_a.trap_valid = 1'b0;      bus_a.trap_pc = 16'h0;
        bus_a.redirect_valid = 1'b0; bus_a.redirect_pc = 16'h0;    bus_a.btb_upd_valid = 1'b0;
        bus_a.btb_upd_pc = 16'h0;    bus_a.btb_upd_target = 16'h0; bus_a.btb_upd_taken = 1'b0;
    endtask

    task automatic idle_b();
        bus_b.stall_F = 1'b0;        bus_b.trap_valid = 1'b0;      bus_b.trap_pc = 12'h0;
        bus_b.redirect_valid = 1'b0; bus_b.redirect_pc = 12'h0;    bus_b.btb_upd_valid = 1'b0;
        bus_b.btb_upd_pc = 12'h0;    bus_b.btb_upd_target = 12'h0; bus_b.btb_upd_taken = 1'b0;
    endtask

    task automatic upd_a(input int pc, input int tgt, input bit taken);
        bus_a.btb_upd_valid  = 1'b1;
        bus_a.btb_upd_pc     = 16'(pc);
        bus_a.btb_upd_target = 16'(tgt);
        bus_a.btb_upd_taken  = taken;
    endtask

    task automatic redir_a(input int pc);
        bus_a.redirect_valid = 1'b1;
        bus_a.redirect_pc    = 16'(pc);
    endtask

    // One clock for both DUTs; the model of dut_a follows the priority rules
    task automatic tick();
        int nxt;
        int i;
        int seq;
        bit hit;
        hit = m_hit(m_pc);
        seq = (m_pc + STEP_A) % MOD_A;
        if (rst_a)                     nxt = 0;
        else if (bus_a.trap_valid)     nxt = int'(bus_a.trap_pc);
        else if (bus_a.redirect_valid) nxt = int'(bus_a.redirect_pc);
        else if (bus_a.stall_F)        nxt = m_pc;
        else if (hit)                  nxt = m_g[m_idx(m_pc)];
        else                           nxt = seq;
        if (rst_a) begin
            for (int k = 0; k < DEPTH_A; k++) m_v[k] = 1'b0;
        end else if (bus_a.btb_upd_valid) begin
            i = m_idx(int'(bus_a.btb_upd_pc));
            if (bus_a.btb_upd_taken) begin
                m_v[i] = 1'b1;
                m_t[i] = m_tag(int'(bus_a.btb_upd_pc));
                m_g[i] = int'(bus_a.btb_upd_target);
            end else if (m_v[i] && m_t[i] == m_tag(int'(bus_a.btb_upd_pc))) begin
                m_v[i] = 1'b0;
            end
        end
        @(posedge clk);
        #1;
        m_pc = nxt;
        hit  = m_hit(m_pc);
        seq  = (m_pc + STEP_A) % MOD_A;
        chk("a_pc_f", 32'(bus_a.PC_F), m_pc);
        chk("a_pc_next", 32'(bus_a.PC_next), seq);
        chk("a_pred_taken", 32'(bus_a.pred_taken_F), 32'(hit));
        chk("a_pred_target", 32'(bus_a.pred_target_F), hit ? m_g[m_idx(m_pc)] : seq);
    endtask

    initial begin
        m_pc = 0;
        for (int k = 0; k < DEPTH_A; k++) begin
            m_v[k] = 1'b0; m_t[k] = 0; m_g[k] = 0;
        end
        idle_a(); idle_b();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        rst_a = 1'b0; rst_b = 1'b0;
        chk("a_reset_pc", 32'(bus_a.PC_F), 32'h0);
        chk("a_reset_pred", 32'(bus_a.pred_taken_F), 32'h0);
        chk("b_reset_pc", 32'(bus_b.PC_F), 32'h100);
        chk("b_reset_next", 32'(bus_b.PC_next), 32'h104);
        chk("b_reset_target", 32'(bus_b.pred_target_F), 32'h104);

        // Sequencing, then training while PC_F=2
        tick(); chk("a_seq1", 32'(bus_a.PC_F), 32'h1); chk("b_seq1", 32'(bus_b.PC_F), 32'h104);
        tick(); chk("a_seq2", 32'(bus_a.PC_F), 32'h2); chk("b_seq2", 32'(bus_b.PC_F), 32'h108);
        upd_a(5, 16'h40, 1'b1);
        bus_b.btb_upd_valid = 1'b1; bus_b.btb_upd_pc = 12'h110;
        bus_b.btb_upd_target = 12'h7F3; bus_b.btb_upd_taken = 1'b1;
        tick(); idle_a(); idle_b();
        chk("a_seq3", 32'(bus_a.PC_F), 32'h3); chk("b_seq3", 32'(bus_b.PC_F), 32'h10C);
        tick();
        chk("b_hit_taken", 32'(bus_b.pred_taken_F), 32'h1);
        chk("b_hit_target", 32'(bus_b.pred_target_F), 32'h7F3);
        tick();
        chk("a_hit_pc", 32'(bus_a.PC_F), 32'h5);
        chk("a_hit_taken", 32'(bus_a.pred_taken_F), 32'h1);
        chk("a_hit_target", 32'(bus_a.pred_target_F), 32'h40);
        chk("b_unaligned_pc", 32'(bus_b.PC_F), 32'h7F3);
        tick();
        chk("a_follow_pc", 32'(bus_a.PC_F), 32'h40);
        chk("b_seq_unaligned", 32'(bus_b.PC_F), 32'h7F7);
        bus_b.redirect_valid = 1'b1; bus_b.redirect_pc = 12'hFFC;
        tick(); idle_b();
        chk("a_follow_seq", 32'(bus_a.PC_F), 32'h41);
        chk("b_top_pc", 32'(bus_b.PC_F), 32'hFFC);
        chk("b_top_next", 32'(bus_b.PC_next), 32'h000);
        tick();
        chk("b_wrap_pc", 32'(bus_b.PC_F), 32'h000);

        // Aliasing and untraining
        upd_a(21, 16'h80, 1'b1); tick(); idle_a();
        redir_a(5); tick();
        chk("alias_5_miss", 32'(bus_a.pred_taken_F), 32'h0);
        redir_a(21); tick();
        chk("alias_21_hit", 32'(bus_a.pred_taken_F), 32'h1);
        chk("alias_21_target", 32'(bus_a.pred_target_F), 32'h80);
        idle_a(); upd_a(5, 0, 1'b0); tick(); idle_a();
        redir_a(21); tick();
        chk("untrain5_keeps21", 32'(bus_a.pred_taken_F), 32'h1);
        upd_a(21, 0, 1'b0); tick(); idle_a();
        chk("untrain21_miss", 32'(bus_a.pred_taken_F), 32'h0);

        // Priority among trap, redirect, stall and prediction
        upd_a(16'h10, 16'h50, 1'b1); redir_a(16'h10); tick(); idle_a();
        chk("prio_hit", 32'(bus_a.pred_taken_F), 32'h1);
        bus_a.stall_F = 1'b1; tick(); tick();
        chk("prio_stall_hold", 32'(bus_a.PC_F), 32'h10);
        redir_a(16'h200); bus_a.trap_valid = 1'b1; bus_a.trap_pc = 16'h300; tick();
        chk("prio_trap", 32'(bus_a.PC_F), 32'h300);
        bus_a.trap_valid = 1'b0; tick(); idle_a();
        chk("prio_redirect", 32'(bus_a.PC_F), 32'h200);

        // Update/lookup collision, then wrap
        redir_a(16'h30); tick(); idle_a();
        upd_a(16'h30, 16'h99, 1'b1);
        #1;
        chk("collision_no_bypass", 32'(bus_a.pred_taken_F), 32'h0);
        tick(); idle_a();
        chk("collision_seq", 32'(bus_a.PC_F), 32'h31);
        redir_a(16'h30); tick(); idle_a();
        chk("collision_refetch_hit", 32'(bus_a.pred_taken_F), 32'h1);
        chk("collision_refetch_tgt", 32'(bus_a.pred_target_F), 32'h99);
        redir_a(16'hFFFF); tick(); idle_a();
        chk("wrap_top_next", 32'(bus_a.PC_next), 32'h0);
        tick();
        chk("wrap_pc", 32'(bus_a.PC_F), 32'h0);

        // Reset mid-run discards concurrent trap and update
        upd_a(16'h60, 16'h1234, 1'b1); tick();
        upd_a(16'h61, 16'h2345, 1'b1); tick();
        upd_a(16'h62, 16'h3456, 1'b1); tick();
        upd_a(16'h63, 16'h4567, 1'b1);
        bus_a.trap_valid = 1'b1; bus_a.trap_pc = 16'h777;
        rst_a = 1'b1; tick(); rst_a = 1'b0; idle_a();
        chk("midrst_pc", 32'(bus_a.PC_F), 32'h0);
        for (int p = 16'h60; p <= 16'h63; p++) begin
            redir_a(p); tick();
            chk("midrst_miss", 32'(bus_a.pred_taken_F), 32'h0);
        end
        idle_a();

        // Randomized traffic in a small address window so entries get reused
        for (int n = 0; n < 400; n++) begin
            rst_a                = ($urandom_range(0, 99) < 2);
            bus_a.trap_valid     = ($urandom_range(0, 99) < 5);
            bus_a.trap_pc        = 16'($urandom_range(0, 63));
            bus_a.redirect_valid = ($urandom_range(0, 99) < 12);
            bus_a.redirect_pc    = ($urandom_range(0, 9) == 0) ? 16'($urandom_range(65530, 65535))
                                                                : 16'($urandom_range(0, 63));
            bus_a.stall_F        = ($urandom_range(0, 99) < 20);
            bus_a.btb_upd_valid  = ($urandom_range(0, 99) < 40);
            bus_a.btb_upd_pc     = 16'($urandom_range(0, 63));
            bus_a.btb_upd_target = ($urandom_range(0, 9) == 0) ? 16'($urandom)
                                                                : 16'($urandom_range(0, 63));
            bus_a.btb_upd_taken  = ($urandom_range(0, 99) < 70);
            tick();
        end
        rst_a = 1'b0; idle_a();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
